// File: rtl/riscv_instr_arb_pkg.sv
// Shared types and limits for the instruction-port arbiter.
package riscv_instr_arb_pkg;

   localparam int unsigned MAX_OUTSTANDING_LIMIT = 4;

   typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;
   typedef enum logic {OWNER_M0, OWNER_M1} arb_owner_e;

endpackage

// File: rtl/riscv_instr_port_arbiter_if.sv
// One req/gnt/rvalid instruction fetch port; master issues requests, slave answers them.
interface riscv_instr_port_arbiter_if;
   logic        req;
   logic [31:0] addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err_pmp;

   modport master (output req, output addr, input gnt, input rvalid, input rdata, input err_pmp);
   modport slave  (input req, input addr, output gnt, output rvalid, output rdata, output err_pmp);
endinterface

// File: rtl/riscv_instr_arb_owner_fifo.sv
// In-order FIFO of requester ids for granted transactions awaiting rvalid.
module riscv_instr_arb_owner_fifo
   import riscv_instr_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  arb_owner_e push_id,
   input  logic       pop,
   output arb_owner_e head_id,
   output logic       full,
   output logic       empty
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   arb_owner_e    mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [CW-1:0] cnt_q;
   logic          do_push;
   logic          do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot a push into a full FIFO needs.
   assign do_push = push & (~full | do_pop);
   assign head_id = mem_q[rd_ptr_q];

   // Storage, pointers and occupancy count.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= OWNER_M0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_id;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/riscv_instr_port_arbiter.sv
// Shares one instruction-memory port between the prefetch buffer (M0) and a debug/aux fetcher (M1).
module riscv_instr_port_arbiter
   import riscv_instr_arb_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter bit          M0_PRIORITY     = 1'b0
) (
   input  logic                        clk,
   input  logic                        rst,
   riscv_instr_port_arbiter_if.slave   m0,
   riscv_instr_port_arbiter_if.slave   m1,
   riscv_instr_port_arbiter_if.master  mem,
   output logic                        busy_o,
   output logic                        proto_err_o
);

   if (MAX_OUTSTANDING == 0 || MAX_OUTSTANDING > MAX_OUTSTANDING_LIMIT) begin : g_param_check
      $error("riscv_instr_port_arbiter: MAX_OUTSTANDING must be 1..%0d", MAX_OUTSTANDING_LIMIT);
   end

   arb_state_e state_q, state_d;
   arb_owner_e owner_q, owner_d;
   arb_owner_e rr_last_q;
   arb_owner_e sel_id;
   arb_owner_e head_id;
   logic       sel_req;
   logic       mem_req_c;
   logic       push;
   logic       pop;
   logic       fifo_full;
   logic       fifo_empty;

   // Selection, combinational port muxes and next-state logic.
   always_comb begin
      sel_id      = OWNER_M0;
      sel_req     = 1'b0;
      state_d     = state_q;
      owner_d     = owner_q;
      mem_req_c   = 1'b0;
      mem.req     = 1'b0;
      mem.addr    = '0;
      m0.gnt      = 1'b0;
      m1.gnt      = 1'b0;
      m0.err_pmp  = 1'b0;
      m1.err_pmp  = 1'b0;
      m0.rvalid   = 1'b0;
      m1.rvalid   = 1'b0;
      m0.rdata    = mem.rdata;
      m1.rdata    = mem.rdata;
      push        = 1'b0;
      pop         = 1'b0;

      // While locked the owner keeps the port; otherwise arbitrate fresh.
      if (state_q == ARB_LOCKED) begin
         sel_id  = owner_q;
         sel_req = (owner_q == OWNER_M1) ? m1.req : m0.req;
      end else if (m0.req && m1.req) begin
         sel_req = 1'b1;
         sel_id  = (M0_PRIORITY || rr_last_q == OWNER_M1) ? OWNER_M0 : OWNER_M1;
      end else if (m1.req) begin
         sel_req = 1'b1;
         sel_id  = OWNER_M1;
      end else if (m0.req) begin
         sel_req = 1'b1;
         sel_id  = OWNER_M0;
      end

      // A same-cycle return frees a slot, so a full FIFO can still issue.
      mem_req_c = sel_req & (~fifo_full | mem.rvalid) & ~rst;
      mem.req   = mem_req_c;
      if (sel_req) mem.addr = (sel_id == OWNER_M1) ? m1.addr : m0.addr;

      m0.gnt     = mem_req_c & mem.gnt & (sel_id == OWNER_M0);
      m1.gnt     = mem_req_c & mem.gnt & (sel_id == OWNER_M1);
      m0.err_pmp = mem_req_c & mem.err_pmp & (sel_id == OWNER_M0);
      m1.err_pmp = mem_req_c & mem.err_pmp & (sel_id == OWNER_M1);

      // PMP-faulted requests never return data, so they are not tracked.
      push = mem_req_c & mem.gnt & ~mem.err_pmp;
      pop  = mem.rvalid & ~fifo_empty & ~rst;
      m0.rvalid = pop & (head_id == OWNER_M0);
      m1.rvalid = pop & (head_id == OWNER_M1);

      case (state_q)
         ARB_IDLE: begin
            if (mem_req_c && !mem.gnt && !mem.err_pmp) begin
               state_d = ARB_LOCKED;
               owner_d = sel_id;
            end
         end
         ARB_LOCKED: begin
            if (!sel_req || (mem_req_c && (mem.gnt || mem.err_pmp))) state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   assign busy_o = (~fifo_empty | mem_req_c) & ~rst;

   // FSM state, lock owner, round-robin history and sticky protocol error.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ARB_IDLE;
         owner_q     <= OWNER_M0;
         rr_last_q   <= OWNER_M1;
         proto_err_o <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         if (push) rr_last_q <= sel_id;
         if (mem.rvalid && fifo_empty) proto_err_o <= 1'b1;
      end
   end

   riscv_instr_arb_owner_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_owner_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .push_id (sel_id),
      .pop     (pop),
      .head_id (head_id),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

endmodule
